mmio_fifo_bank: RTL and testbench
=================================

Name: mmio_fifo_bank

Overview:
- Parametrised N-channel successor to the fixed pair of 512-entry MMIO FIFOs beside cpu_and_mem.
- Each channel is a single-clock, first-word-fall-through FIFO in distributed RAM.
- Adds per-channel occupancy, almost-full/almost-empty flags, sticky overflow/underflow error flags, flush and error-clear controls.
- Sits in the i_clk domain between the CPU MMIO decode and software-managed buffers.

Parameters:
- NUM_CHANNELS, 2, number of independent FIFO channels (1..8).
- DATA_WIDTH, 32, entry width in bits.
- ADDR_WIDTH, 9, log2 of depth; DEPTH = 2**ADDR_WIDTH entries per channel, all usable.
- AFULL_LEVEL, 448, o_almost_full[c] asserted when level >= AFULL_LEVEL (1..DEPTH).
- AEMPTY_LEVEL, 64, o_almost_empty[c] asserted when level <= AEMPTY_LEVEL (0..DEPTH-1).

Ports:
- i_clk  in  1  CPU clock.
- i_rst  in  1  reset.
- i_wr_en  in  NUM_CHANNELS  per-channel push strobe.
- i_wr_data  in  NUM_CHANNELS x DATA_WIDTH  per-channel push data.
- i_rd_en  in  NUM_CHANNELS  per-channel pop strobe (acknowledges the head).
- o_rd_data  out  NUM_CHANNELS x DATA_WIDTH  head entry, valid while ~o_empty[c].
- o_empty  out  NUM_CHANNELS  level == 0.
- o_full  out  NUM_CHANNELS  level == DEPTH.
- o_almost_full  out  NUM_CHANNELS  level >= AFULL_LEVEL.
- o_almost_empty  out  NUM_CHANNELS  level <= AEMPTY_LEVEL.
- o_level  out  NUM_CHANNELS x (ADDR_WIDTH+1)  entries held.
- i_flush  in  NUM_CHANNELS  discard channel contents.
- i_clr_err  in  NUM_CHANNELS  clear sticky error flags.
- o_overflow  out  NUM_CHANNELS  sticky: a push was dropped.
- o_underflow  out  NUM_CHANNELS  sticky: a pop was attempted while empty.
- o_any_not_empty  out  1  registered OR of ~o_empty, for interrupt use.

Behaviour:
- Clocking and reset: single clock i_clk; reset i_rst is synchronous, active-high.
- Reset values: pointers = 0, level = 0, o_empty = 1, o_full = 0, o_almost_empty = 1, o_almost_full = 0, o_overflow = o_underflow = 0, o_any_not_empty = 0, o_rd_data = don't-care. RAM contents are not reset.
- Flags: all status flags are registered and consistent with o_level in the same cycle.
- Pointers: wr_ptr and rd_ptr are ADDR_WIDTH bits wide and wrap modulo DEPTH.
- Level: level is a separate ADDR_WIDTH+1 counter.
- Read path: FWFT. o_rd_data = mem[rd_ptr] combinationally from RAM, so a pushed word is visible the cycle after the push edge. Push-to-visible latency is 1 cycle; pop advances the head at the edge.
- Per-channel priority each edge: i_rst > i_flush > normal operation.
- Normal operation:
  - push_ok = wr_en & (~full | rd_en_ok).
  - rd_en_ok = rd_en & ~empty.
  - Writes go to mem[wr_ptr], then wr_ptr++.
  - Pops do rd_ptr++.
  - level += push_ok - rd_en_ok.
- Full with simultaneous push and pop: both accepted, level unchanged.
- Empty with simultaneous push and pop: push accepted, pop ignored, o_underflow set, level becomes 1.
- Push while full with no pop: data dropped; o_overflow set next cycle; pointers and level unchanged.
- Pop while empty: ignored; o_underflow set.
- i_flush: wr_ptr = rd_ptr = 0, level = 0. A concurrent wr_en/rd_en that cycle is discarded and does not set error flags. Error flags are unaffected by flush.
- i_clr_err: clears both sticky flags. If an error event occurs in the same cycle, set wins.
- Channel independence: channels are fully independent; no cross-channel arbitration.
- o_any_not_empty: lags o_empty by one cycle.
- Reset mid-burst: all state is returned to reset values at the edge; in-flight strobes that cycle are ignored.

Decomposition:
- Package mmio_fifo_pkg:
  - MaxChannels = 8 constant.
  - Function level_width(addr_w) = addr_w + 1.
  - Enum fifo_err_e {ERR_NONE, ERR_OVERFLOW, ERR_UNDERFLOW} for bench and CSR decode.
- Sub-module mmio_fifo_channel: one channel holding RAM, pointers, level, flags and error logic.
- mmio_fifo_bank: generate loop over NUM_CHANNELS plus the o_any_not_empty OR register.
- Parameter checks: AFULL_LEVEL in 1..DEPTH and AEMPTY_LEVEL < DEPTH, enforced by elaboration-time assertions.

Test Plan:
Bench parameters: NUM_CHANNELS=4, ADDR_WIDTH=4 (DEPTH=16), AFULL_LEVEL=12, AEMPTY_LEVEL=2.
1. Reset, then push 0xA0..0xAF into ch0 → o_full[0]=1 and o_level[0]=16. Other channels stay empty. Popping 16 times yields 0xA0..0xAF in order, then o_empty[0]=1.
2. Fill ch1 to 16, then push 0xDEAD → dropped and o_overflow[1]=1. Next pop returns the original first word. i_clr_err[1] → o_overflow[1]=0.
3. ch2 at level 16, simultaneous push 0x55 and pop → level stays 16. After draining, 0x55 is the last word.
4. ch3 empty, simultaneous push 0x77 and pop → o_level[3]=1, o_underflow[3]=1, o_rd_data[3]=0x77.
5. ch0 at level 11: push → o_almost_full=1 at 12. At level 3, pop → o_almost_empty=1 at 2.
6. Push 5 into ch1, then i_flush[1] with concurrent push → o_level[1]=0 and o_empty[1]=1, with no new error flags. Reset asserted mid-burst on all channels → every output at its reset value on the next cycle.

Source files
------------

// File: rtl/mmio_fifo_pkg.sv
// Shared constants, helpers and error codes for the MMIO FIFO bank.
package mmio_fifo_pkg;

    localparam int unsigned MaxChannels = 8;

    function automatic int unsigned level_width(input int unsigned addr_w);
        return addr_w + 1;
    endfunction

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_OVERFLOW,
        ERR_UNDERFLOW
    } fifo_err_e;

endpackage

// File: rtl/mmio_fifo_channel.sv
// One FWFT FIFO channel: RAM, pointers, level counter, status and sticky error flags.
module mmio_fifo_channel
    import mmio_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 9,
    parameter int unsigned AFULL_LEVEL  = 448,
    parameter int unsigned AEMPTY_LEVEL = 64
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic                                  i_wr_en,
    input  logic [DATA_WIDTH-1:0]                 i_wr_data,
    input  logic                                  i_rd_en,
    input  logic                                  i_flush,
    input  logic                                  i_clr_err,
    output logic [DATA_WIDTH-1:0]                 o_rd_data,
    output logic                                  o_empty,
    output logic                                  o_full,
    output logic                                  o_almost_full,
    output logic                                  o_almost_empty,
    output logic [level_width(ADDR_WIDTH)-1:0]    o_level,
    output logic                                  o_overflow,
    output logic                                  o_underflow
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned LW    = level_width(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  empty_q, full_q, afull_q, aempty_q;
    logic                  ovf_q, ovf_d, udf_q, udf_d;
    logic                  rd_ok, push_ok, ovf_ev, udf_ev;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        rd_ok    = i_rd_en & ~empty_q;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
        push_ok  = i_wr_en & (~full_q | rd_ok);
        ovf_ev   = ~i_flush & i_wr_en & ~push_ok;
        udf_ev   = ~i_flush & i_rd_en & empty_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            if (rd_ok)   rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
            level_d = level_q + LW'(push_ok) - LW'(rd_ok);
        end
        // Set has priority over clear
        if (ovf_ev)         ovf_d = 1'b1;
        else if (i_clr_err) ovf_d = 1'b0;
        if (udf_ev)         udf_d = 1'b1;
        else if (i_clr_err) udf_d = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            empty_q  <= (level_d == '0);
            full_q   <= (level_d == LW'(DEPTH));
            afull_q  <= (level_d >= LW'(AFULL_LEVEL));
            aempty_q <= (level_d <= LW'(AEMPTY_LEVEL));
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage is not reset
    always_ff @(posedge i_clk) begin
        if (!i_rst && !i_flush && push_ok) mem_q[wr_ptr_q] <= i_wr_data;
    end

    assign o_rd_data      = mem_q[rd_ptr_q];
    assign o_empty        = empty_q;
    assign o_full         = full_q;
    assign o_almost_full  = afull_q;
    assign o_almost_empty = aempty_q;
    assign o_level        = level_q;
    assign o_overflow     = ovf_q;
    assign o_underflow    = udf_q;

endmodule

// File: rtl/mmio_fifo_bank.sv
// N independent MMIO FIFO channels plus a registered any-not-empty summary for interrupts.
module mmio_fifo_bank
    import mmio_fifo_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS = 2,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 9,
    parameter int unsigned AFULL_LEVEL  = 448,
    parameter int unsigned AEMPTY_LEVEL = 64
) (
    input  logic                                             i_clk,
    input  logic                                             i_rst,
    input  logic [NUM_CHANNELS-1:0]                          i_wr_en,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]               i_wr_data,
    input  logic [NUM_CHANNELS-1:0]                          i_rd_en,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0]               o_rd_data,
    output logic [NUM_CHANNELS-1:0]                          o_empty,
    output logic [NUM_CHANNELS-1:0]                          o_full,
    output logic [NUM_CHANNELS-1:0]                          o_almost_full,
    output logic [NUM_CHANNELS-1:0]                          o_almost_empty,
    output logic [NUM_CHANNELS*level_width(ADDR_WIDTH)-1:0]  o_level,
    input  logic [NUM_CHANNELS-1:0]                          i_flush,
    input  logic [NUM_CHANNELS-1:0]                          i_clr_err,
    output logic [NUM_CHANNELS-1:0]                          o_overflow,
    output logic [NUM_CHANNELS-1:0]                          o_underflow,
    output logic                                             o_any_not_empty
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned LW    = level_width(ADDR_WIDTH);

    if (NUM_CHANNELS < 1 || NUM_CHANNELS > MaxChannels) begin : g_bad_nch
        $error("mmio_fifo_bank: NUM_CHANNELS out of range");
    end
    if (AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : g_bad_afull
        $error("mmio_fifo_bank: AFULL_LEVEL out of range");
    end
    if (AEMPTY_LEVEL >= DEPTH) begin : g_bad_aempty
        $error("mmio_fifo_bank: AEMPTY_LEVEL out of range");
    end

    logic any_q;

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        mmio_fifo_channel #(
            .DATA_WIDTH  (DATA_WIDTH),
            .ADDR_WIDTH  (ADDR_WIDTH),
            .AFULL_LEVEL (AFULL_LEVEL),
            .AEMPTY_LEVEL(AEMPTY_LEVEL)
        ) u_ch (
            .i_clk         (i_clk),
            .i_rst         (i_rst),
            .i_wr_en       (i_wr_en[c]),
            .i_wr_data     (i_wr_data[c*DATA_WIDTH +: DATA_WIDTH]),
            .i_rd_en       (i_rd_en[c]),
            .i_flush       (i_flush[c]),
            .i_clr_err     (i_clr_err[c]),
            .o_rd_data     (o_rd_data[c*DATA_WIDTH +: DATA_WIDTH]),
            .o_empty       (o_empty[c]),
            .o_full        (o_full[c]),
            .o_almost_full (o_almost_full[c]),
            .o_almost_empty(o_almost_empty[c]),
            .o_level       (o_level[c*LW +: LW]),
            .o_overflow    (o_overflow[c]),
            .o_underflow   (o_underflow[c])
        );
    end

    // Deliberately one cycle behind o_empty
    always_ff @(posedge i_clk) begin
        if (i_rst) any_q <= 1'b0;
        else       any_q <= |(~o_empty);
    end

    assign o_any_not_empty = any_q;

endmodule

// File: tb/tb_mmio_fifo_bank.sv
// Self-checking bench for mmio_fifo_bank: directed table, hand sequences and queue-model random run.
module tb_mmio_fifo_bank;
    import mmio_fifo_pkg::*;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int D  = 16;
    localparam int LW = AW + 1;
    localparam int AF = 12;
    localparam int AE = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    wr_en, rd_en, flush, clr_err;
    logic [N*DW-1:0] wr_data;
    logic [N*DW-1:0] rd_data;
    logic [N-1:0]    empty, full, afull, aempty, ovf, udf;
    logic [N*LW-1:0] level;
    logic            any_ne;

    always #5 clk = ~clk;

    mmio_fifo_bank #(
        .NUM_CHANNELS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .AFULL_LEVEL(AF), .AEMPTY_LEVEL(AE)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_data(wr_data),
        .i_rd_en(rd_en), .o_rd_data(rd_data), .o_empty(empty), .o_full(full),
        .o_almost_full(afull), .o_almost_empty(aempty), .o_level(level),
        .i_flush(flush), .i_clr_err(clr_err), .o_overflow(ovf),
        .o_underflow(udf), .o_any_not_empty(any_ne)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: one queue per channel plus sticky flags
    logic [DW-1:0] mq [N][$];
    bit            m_ovf [N];
    bit            m_udf [N];
    bit            m_any;

    task automatic chk(input string nm, input int c, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s ch%0d: got %0h expected %0h (t=%0t)", nm, c, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] lvl(input int c);
        return DW'(level[c*LW +: LW]);
    endfunction

    function automatic logic [DW-1:0] head(input int c);
        return rd_data[c*DW +: DW];
    endfunction

    task automatic model_update(input logic [N-1:0] wr, input logic [N-1:0] rd,
                                input logic [N-1:0] fl, input logic [N-1:0] clr,
                                input logic [N*DW-1:0] d, input bit r);
        bit any_next;
        any_next = 1'b0;
        for (int c = 0; c < N; c++) if (mq[c].size() != 0) any_next = 1'b1;
        for (int c = 0; c < N; c++) begin
            bit ev_o, ev_u, pop_ok, push_ok;
            ev_o = 1'b0;
            ev_u = 1'b0;
            if (r) begin
                mq[c].delete();
                m_ovf[c] = 1'b0;
                m_udf[c] = 1'b0;
                continue;
            end
            if (fl[c]) begin
                mq[c].delete();
            end else begin
                pop_ok  = rd[c] && mq[c].size() > 0;
                push_ok = wr[c] && (mq[c].size() < D || pop_ok);
                ev_o    = wr[c] && !push_ok;
                ev_u    = rd[c] && mq[c].size() == 0;
                if (pop_ok)  void'(mq[c].pop_front());
                if (push_ok) mq[c].push_back(d[c*DW +: DW]);
            end
            if (ev_o) m_ovf[c] = 1'b1; else if (clr[c]) m_ovf[c] = 1'b0;
            if (ev_u) m_udf[c] = 1'b1; else if (clr[c]) m_udf[c] = 1'b0;
        end
        m_any = r ? 1'b0 : any_next;
    endtask

    task automatic check_model();
        for (int c = 0; c < N; c++) begin
            int sz;
            sz = mq[c].size();
            chk("level",  c, lvl(c), DW'(sz));
            chk("empty",  c, DW'(empty[c]),  DW'(sz == 0));
            chk("full",   c, DW'(full[c]),   DW'(sz == D));
            chk("afull",  c, DW'(afull[c]),  DW'(sz >= AF));
            chk("aempty", c, DW'(aempty[c]), DW'(sz <= AE));
            chk("ovf",    c, DW'(ovf[c]),    DW'(m_ovf[c]));
            chk("udf",    c, DW'(udf[c]),    DW'(m_udf[c]));
            if (sz > 0) chk("rd_data", c, head(c), mq[c][0]);
        end
        chk("any_not_empty", 0, DW'(any_ne), DW'(m_any));
    endtask

    // One clock: drive, edge, update model, sample 1 time unit later, compare
    task automatic step(input logic [N-1:0] wr, input logic [N-1:0] rd,
                        input logic [N-1:0] fl, input logic [N-1:0] clr,
                        input logic [N*DW-1:0] d, input bit r);
        wr_en = wr; rd_en = rd; flush = fl; clr_err = clr; wr_data = d; rst = r;
        @(posedge clk);
        model_update(wr, rd, fl, clr, d, r);
        #1;
        check_model();
        wr_en = '0; rd_en = '0; flush = '0; clr_err = '0; rst = 1'b0;
    endtask

    task automatic push(input int c, input logic [DW-1:0] v);
        step(N'(1 << c), '0, '0, '0, {N{v}}, 1'b0);
    endtask

    task automatic pop(input int c);
        step('0, N'(1 << c), '0, '0, '0, 1'b0);
    endtask

    task automatic check_reset_values();
        for (int c = 0; c < N; c++) begin
            chk("rst_level",  c, lvl(c), 0);
            chk("rst_empty",  c, DW'(empty[c]), 1);
            chk("rst_full",   c, DW'(full[c]), 0);
            chk("rst_afull",  c, DW'(afull[c]), 0);
            chk("rst_aempty", c, DW'(aempty[c]), 1);
            chk("rst_ovf",    c, DW'(ovf[c]), 0);
            chk("rst_udf",    c, DW'(udf[c]), 0);
        end
        chk("rst_any", 0, DW'(any_ne), 0);
    endtask

    typedef struct {
        logic [N-1:0]  wr, rd, fl, clr;
        logic [DW-1:0] data;
        int            ch;
        int            exp_lvl;
        bit            exp_ovf, exp_udf, dv;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t vt [$];

    initial begin
        rst = 1'b1; wr_en = '0; rd_en = '0; flush = '0; clr_err = '0; wr_data = '0;
        for (int c = 0; c < N; c++) begin m_ovf[c] = 0; m_udf[c] = 0; end
        m_any = 0;

        step('0, '0, '0, '0, '0, 1'b1);
        step('0, '0, '0, '0, '0, 1'b1);
        check_reset_values();

        // Fill ch0 to full, drain in order
        for (int i = 0; i < D; i++) push(0, DW'(32'hA0 + i));
        chk("t1_full", 0, DW'(full[0]), 1);
        chk("t1_level", 0, lvl(0), 16);
        for (int c = 1; c < N; c++) chk("t1_other_empty", c, DW'(empty[c]), 1);
        for (int i = 0; i < D; i++) begin
            chk("t1_order", 0, head(0), DW'(32'hA0 + i));
            pop(0);
        end
        chk("t1_empty", 0, DW'(empty[0]), 1);

        // Overflow on ch1
        for (int i = 0; i < D; i++) push(1, DW'(32'hB0 + i));
        push(1, 32'hDEAD);
        chk("t2_ovf", 1, DW'(ovf[1]), 1);
        chk("t2_level", 1, lvl(1), 16);
        chk("t2_head", 1, head(1), 32'hB0);
        pop(1);
        chk("t2_next", 1, head(1), 32'hB1);
        step('0, '0, '0, 4'b0010, '0, 1'b0);
        chk("t2_clr", 1, DW'(ovf[1]), 0);
        step('0, '0, 4'b0010, '0, '0, 1'b0);

        // Full with simultaneous push/pop on ch2
        for (int i = 0; i < D; i++) push(2, DW'(32'hC0 + i));
        step(4'b0100, 4'b0100, '0, '0, {N{32'h55}}, 1'b0);
        chk("t3_level", 2, lvl(2), 16);
        chk("t3_noovf", 2, DW'(ovf[2]), 0);
        for (int i = 0; i < D; i++) begin
            if (i == D - 1) chk("t3_last", 2, head(2), 32'h55);
            pop(2);
        end

        // Almost-full / almost-empty thresholds on ch0
        for (int i = 0; i < 11; i++) push(0, DW'(i));
        chk("t5_af11", 0, DW'(afull[0]), 0);
        push(0, 32'h11);
        chk("t5_af12", 0, DW'(afull[0]), 1);
        for (int i = 0; i < 9; i++) pop(0);
        chk("t5_ae3", 0, DW'(aempty[0]), 0);
        pop(0);
        chk("t5_ae2", 0, DW'(aempty[0]), 1);
        step('0, '0, 4'b0001, '0, '0, 1'b0);

        // Table: empty push+pop on ch3, then flush-with-push on ch1
        vt.push_back('{4'b1000, 4'b1000, 4'b0000, 4'b0000, 32'h77, 3, 1, 0, 1, 1, 32'h77});
        vt.push_back('{4'b0000, 4'b0000, 4'b0000, 4'b1000, 32'h00, 3, 1, 0, 0, 1, 32'h77});
        vt.push_back('{4'b0000, 4'b1000, 4'b0000, 4'b0000, 32'h00, 3, 0, 0, 0, 0, 32'h00});
        for (int i = 0; i < 5; i++)
            vt.push_back('{4'b0010, 4'b0000, 4'b0000, 4'b0000, DW'(32'h10 + i), 1, i + 1, 0, 0, 1, 32'h10});
        vt.push_back('{4'b0010, 4'b0010, 4'b0010, 4'b0000, 32'h99, 1, 0, 0, 0, 0, 32'h00});
        foreach (vt[i]) begin
            step(vt[i].wr, vt[i].rd, vt[i].fl, vt[i].clr, {N{vt[i].data}}, 1'b0);
            chk("vec_level", vt[i].ch, lvl(vt[i].ch), DW'(vt[i].exp_lvl));
            chk("vec_ovf",   vt[i].ch, DW'(ovf[vt[i].ch]), DW'(vt[i].exp_ovf));
            chk("vec_udf",   vt[i].ch, DW'(udf[vt[i].ch]), DW'(vt[i].exp_udf));
            chk("vec_empty", vt[i].ch, DW'(empty[vt[i].ch]), DW'(vt[i].exp_lvl == 0));
            if (vt[i].dv) chk("vec_data", vt[i].ch, head(vt[i].ch), vt[i].exp_data);
        end

        // Reset mid-burst on all channels
        for (int i = 0; i < 6; i++) step('1, 4'b0101, '0, '0, {N{DW'(i)}}, 1'b0);
        step('1, '1, '0, '0, {N{32'hFF}}, 1'b1);
        check_reset_values();

        // Randomised traffic against the queue model
        for (int i = 0; i < 4000; i++) begin
            logic [N-1:0] w, r, f, cl;
            logic [N*DW-1:0] d;
            w = N'($urandom);
            r = N'($urandom) & N'($urandom | (i[9] ? 32'h0 : 32'hF));
            f = '0; cl = '0;
            for (int c = 0; c < N; c++) begin
                f[c]  = ($urandom_range(0, 40) == 0);
                cl[c] = ($urandom_range(0, 15) == 0);
            end
            for (int c = 0; c < N; c++) d[c*DW +: DW] = $urandom;
            step(w, r, f, cl, d, $urandom_range(0, 700) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
